// File: rtl/ncsp_mash_gen.sv
// ncsp_mash_gen: MASH 1-1-...-1 delta-sigma modulator for fractional-N divider control.
// Cascaded first-order accumulators; carries recombined through a (1-z^-1)^(k-1)
// noise-cancellation network into one signed divider offset. Runtime order select,
// LFSR dither on the stage-1 LSB, clock enable and atomic reload.
module ncsp_mash_gen #(
    parameter int          P_DATA_WIDTH = 8,
    parameter int          P_MAX_ORDER  = 3,
    parameter int          P_OUT_WIDTH  = 4,
    parameter logic [14:0] P_LFSR_SEED  = 15'h1ACE
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_load,
    input  logic [P_DATA_WIDTH-1:0] i_frac,
    input  logic [P_DATA_WIDTH-1:0] i_seed,
    input  logic [1:0]              i_order,
    input  logic                    i_dither_en,
    output logic [P_OUT_WIDTH-1:0]  o_y,
    output logic                    o_valid
);

    localparam int          W         = P_DATA_WIDTH;
    localparam int          N         = P_MAX_ORDER;
    // carry history depth: stage k needs k-1 prior carries
    localparam int          HD        = (N > 1) ? N - 1 : 1;
    localparam logic [1:0]  ORDER_MAX = 2'(N - 1);

    logic [W-1:0]           frac_q, frac_d;
    logic [1:0]             order_q, order_d;
    logic [W-1:0]           acc_q  [N];
    logic [W-1:0]           acc_d  [N];
    logic [N-1:0]           hist_q [HD];
    logic [N-1:0]           hist_d [HD];
    logic [14:0]            lfsr_q, lfsr_d;
    logic [P_OUT_WIDTH-1:0] y_q, y_d;
    logic                   valid_q, valid_d;

    logic [N-1:0]           carry;
    logic [N-1:0]           tap [HD+1];
    logic [W:0]             sum;
    logic [W-1:0]           pass;
    logic                   dith;
    int                     y_acc;

    // Signed binomial coefficient of (1-z^-1)^m at delay j.
    function automatic int coef(input int unsigned m, input int unsigned j);
        case (m)
            0: coef = (j == 0) ? 1 : 0;
            1: case (j) 0: coef = 1; 1: coef = -1; default: coef = 0; endcase
            2: case (j) 0: coef = 1; 1: coef = -2; 2: coef = 1; default: coef = 0; endcase
            3: case (j) 0: coef = 1; 1: coef = -3; 2: coef = 3; 3: coef = -1; default: coef = 0; endcase
            default: coef = 0;
        endcase
    endfunction

    // Next-state: load restarts, enabled step ripples the cascade and recombines carries.
    always_comb begin
        frac_d  = frac_q;
        order_d = order_q;
        acc_d   = acc_q;
        hist_d  = hist_q;
        lfsr_d  = lfsr_q;
        y_d     = y_q;
        valid_d = 1'b0;
        carry   = '0;
        sum     = '0;
        pass    = '0;
        dith    = 1'b0;
        y_acc   = 0;
        for (int unsigned j = 0; j <= HD; j++) tap[j] = '0;

        if (i_load) begin
            frac_d  = i_frac;
            order_d = (i_order > ORDER_MAX) ? ORDER_MAX : i_order;
            for (int unsigned k = 0; k < N; k++) acc_d[k] = '0;
            acc_d[0] = i_seed;
            for (int unsigned j = 0; j < HD; j++) hist_d[j] = '0;
            lfsr_d  = P_LFSR_SEED;
            y_d     = '0;
        end else if (i_en) begin
            dith = lfsr_q[0] & i_dither_en;
            // each stage integrates the updated residue of the stage before it
            for (int unsigned k = 0; k < N; k++) begin
                if (k <= 32'(order_q)) begin
                    if (k == 0) sum = {1'b0, acc_q[0]} + {1'b0, frac_q} + (W+1)'(dith);
                    else        sum = {1'b0, acc_q[k]} + {1'b0, pass};
                    carry[k] = sum[W];
                    acc_d[k] = sum[W-1:0];
                    pass     = sum[W-1:0];
                end else begin
                    acc_d[k] = '0;
                end
            end
            // tap[0] is this step's carry vector, tap[j] the carries j steps back
            tap[0] = carry;
            for (int unsigned j = 1; j <= HD; j++) tap[j] = hist_q[j-1];
            for (int unsigned k = 0; k < N; k++) begin
                for (int unsigned j = 0; j <= k; j++) begin
                    if (tap[j][k]) y_acc += coef(k, j);
                end
            end
            hist_d[0] = carry;
            for (int unsigned j = 1; j < HD; j++) hist_d[j] = hist_q[j-1];
            y_d     = y_acc[P_OUT_WIDTH-1:0];
            valid_d = 1'b1;
            lfsr_d  = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
        end
    end

    // State register with synchronous reset taking priority over load and enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frac_q  <= '0;
            order_q <= '0;
            acc_q   <= '{default: '0};
            hist_q  <= '{default: '0};
            lfsr_q  <= P_LFSR_SEED;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            frac_q  <= frac_d;
            order_q <= order_d;
            acc_q   <= acc_d;
            hist_q  <= hist_d;
            lfsr_q  <= lfsr_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign o_y     = y_q;
    assign o_valid = valid_q;

endmodule
